// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: start/instruction inputs and datapath control outputs of the sequencer.
interface instr_sequencer_if;
    logic        s;
    logic [15:0] instr;
    logic        w;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic [15:0] datapath_in;
    logic        err;
    modport master (
        output s, instr,
        input  w, loada, loadb, loadc, loads, asel, bsel, ALUop, shift,
               readnum, writenum, write, vsel, datapath_in, err
    );
    modport slave (
        input  s, instr,
        output w, loada, loadb, loadc, loads, asel, bsel, ALUop, shift,
               readnum, writenum, write, vsel, datapath_in, err
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: Moore control FSM for a MOV/ADD/CMP/AND/MVN datapath.
// Define ISEQ_ILLEGAL_TRAP_EN to trap illegal instructions in HALT (err=1) instead of NOP.
module instr_sequencer (
    input logic               clk,
    input logic               reset,
    instr_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG
`ifdef ISEQ_ILLEGAL_TRAP_EN
        , S_HALT
`endif
    } state_t;

    typedef struct packed {
        logic       w;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] alu_op;
        logic [1:0] shift;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       vsel;
        logic       err;
    } ctrl_t;

`ifdef ISEQ_ILLEGAL_TRAP_EN
    localparam state_t S_ILL = S_HALT;
`else
    localparam state_t S_ILL = S_WAIT;
`endif

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;

    // Outputs are a pure function of (state, ir); evaluating it on the next
    // state lets the outputs be registered yet still track state_q exactly.
    function automatic ctrl_t ctrl_of(input state_t st, input logic [15:0] ir);
        ctrl_t c;
        logic  is_mov;
        logic  is_cmp;
        is_mov     = ir[15:13] == 3'b110;
        is_cmp     = !is_mov && ir[12:11] == 2'b01;
        c          = '0;
        c.w        = st == S_WAIT;
        c.loada    = st == S_GET_A;
        c.loadb    = st == S_GET_B;
        c.readnum  = st == S_GET_A ? ir[10:8] : st == S_GET_B ? ir[2:0] : 3'd0;
        c.write    = st == S_WRITE_IMM || st == S_WRITE_REG;
        c.vsel     = st == S_WRITE_IMM;
        c.writenum = st == S_WRITE_IMM ? ir[10:8] : st == S_WRITE_REG ? ir[7:5] : 3'd0;
        if (st == S_ALU) begin
            c.shift  = ir[4:3];
            c.alu_op = is_mov ? 2'b00 : ir[12:11];
            c.asel   = is_mov || ir[12:11] == 2'b11;
            c.loads  = is_cmp;
            c.loadc  = !is_cmp;
        end
`ifdef ISEQ_ILLEGAL_TRAP_EN
        c.err = st == S_HALT;
`endif
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                state_d = bus.s ? S_DECODE : S_WAIT;
                ir_d    = bus.s ? bus.instr : ir_q;
            end
            S_DECODE: state_d =
                (ir_q[15:13] == 3'b110 && ir_q[12:11] == 2'b10) ? S_WRITE_IMM :
                (ir_q[15:13] == 3'b110 && ir_q[12:11] == 2'b00) ? S_GET_B :
                (ir_q[15:13] == 3'b101 && ir_q[12:11] != 2'b11) ? S_GET_A :
                (ir_q[15:13] == 3'b101)                        ? S_GET_B : S_ILL;
            S_GET_A:     state_d = S_GET_B;
            S_GET_B:     state_d = S_ALU;
            S_ALU:       state_d = (ir_q[15:13] == 3'b101 && ir_q[12:11] == 2'b01) ? S_WAIT : S_WRITE_REG;
            S_WRITE_IMM: state_d = S_WAIT;
            S_WRITE_REG: state_d = S_WAIT;
`ifdef ISEQ_ILLEGAL_TRAP_EN
            S_HALT:      state_d = S_HALT;
`endif
            default:     state_d = S_WAIT;
        endcase
        ctrl_d = ctrl_of(state_d, ir_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            ir_q     <= '0;
            ctrl_q   <= '0;
            ctrl_q.w <= 1'b1;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.w           = ctrl_q.w;
    assign bus.loada       = ctrl_q.loada;
    assign bus.loadb       = ctrl_q.loadb;
    assign bus.loadc       = ctrl_q.loadc;
    assign bus.loads       = ctrl_q.loads;
    assign bus.asel        = ctrl_q.asel;
    assign bus.bsel        = ctrl_q.bsel;
    assign bus.ALUop       = ctrl_q.alu_op;
    assign bus.shift       = ctrl_q.shift;
    assign bus.readnum     = ctrl_q.readnum;
    assign bus.writenum    = ctrl_q.writenum;
    assign bus.write       = ctrl_q.write;
    assign bus.vsel        = ctrl_q.vsel;
    assign bus.err         = ctrl_q.err;
    assign bus.datapath_in = {{8{ir_q[7]}}, ir_q[7:0]};
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random instruction runs checked cycle by cycle against a per-instruction trace model.
module tb_instr_sequencer;
    logic clk = 0;
    logic reset = 1;
    int   total = 0;
    int   bad = 0;

    instr_sequencer_if bus();
    instr_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic       w, la, lb, lc, ls, as, bs;
        logic [1:0] aop, sh;
        logic [2:0] rn, wn;
        logic       wr, vs, err;
    } cyc_t;

    cyc_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cyc_t obs();
        return {bus.w, bus.loada, bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel,
                bus.ALUop, bus.shift, bus.readnum, bus.writenum, bus.write, bus.vsel, bus.err};
    endfunction

    function automatic cyc_t idle();
        cyc_t c = '0;
        c.w = 1;
        return c;
    endfunction

    function automatic bit legal(input logic [15:0] i);
        return (i[15:13] == 3'b110 && (i[12:11] == 2'b10 || i[12:11] == 2'b00)) || i[15:13] == 3'b101;
    endfunction

    function automatic int busy_of(input logic [15:0] i);
        if (!legal(i)) return 1;
        if (i[15:13] == 3'b110) return i[12:11] == 2'b10 ? 2 : 4;
        return (i[12:11] == 2'b00 || i[12:11] == 2'b10) ? 5 : 4;
    endfunction

    // Expected output trace of the busy period, one entry per cycle.
    function automatic void build(input logic [15:0] i);
        logic [2:0] opc = i[15:13], rn = i[10:8], rd = i[7:5], rm = i[2:0];
        logic [1:0] op = i[12:11], sh = i[4:3];
        bit   cmp = opc == 3'b101 && op == 2'b01;
        cyc_t c = '0;
        exp_q.delete();
        exp_q.push_back(c);
        if (!legal(i)) return;
        if (opc == 3'b110 && op == 2'b10) begin
            c.wr = 1; c.vs = 1; c.wn = rn;
            exp_q.push_back(c);
            return;
        end
        if (opc == 3'b101 && op != 2'b11) begin
            c = '0; c.rn = rn; c.la = 1;
            exp_q.push_back(c);
        end
        c = '0; c.rn = rm; c.lb = 1;
        exp_q.push_back(c);
        c = '0; c.sh = sh; c.aop = opc == 3'b110 ? 2'b00 : op;
        c.as = opc == 3'b110 || op == 2'b11;
        c.ls = cmp; c.lc = !cmp;
        exp_q.push_back(c);
        if (!cmp) begin
            c = '0; c.wr = 1; c.wn = rd;
            exp_q.push_back(c);
        end
    endfunction

    task automatic do_reset();
        reset = 1;
        #1;
        check("rst_ctrl", obs(), idle());
        check("rst_dpin", bus.datapath_in, 16'h0000);
        @(negedge clk);
        reset = 0;
    endtask

    // Called at a negedge with the sequencer idle; junk=1 keeps pulsing s with 0xD3FB while busy.
    task automatic run(input logic [15:0] i, input bit junk);
        int   busy = 0;
        cyc_t c;
        logic [15:0] dpin = {{8{i[7]}}, i[7:0]};
        check("idle_w", bus.w, 1'b1);
        bus.s = 1;
        bus.instr = i;
        @(negedge clk);
        build(i);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            check($sformatf("ctrl_%h", i), obs(), c);
            check($sformatf("dpin_%h", i), bus.datapath_in, dpin);
            if (!bus.w) busy++;
            bus.s = junk;
            bus.instr = junk ? 16'hD3FB : 16'h0000;
            @(negedge clk);
        end
        bus.s = 0;
`ifdef ISEQ_ILLEGAL_TRAP_EN
        if (!legal(i)) begin
            c = '0;
            c.err = 1;
            for (int k = 0; k < 4; k++) begin
                check("halt", obs(), c);
                @(negedge clk);
            end
            do_reset();
            check("post_halt_w", bus.w, 1'b1);
            return;
        end
`endif
        check($sformatf("done_%h", i), obs(), idle());
        check($sformatf("busy_%h", i), busy, busy_of(i));
    endtask

    initial begin
        logic [15:0] r;
        bus.s = 0;
        bus.instr = 16'h0000;
        @(negedge clk);
        do_reset();
        check("rst_released", obs(), idle());
        run(16'hD3FB, 0);
        check("movimm_dpin", bus.datapath_in, 16'hFFFB);
        run(16'hA148, 0);
        run(16'hAD06, 0);
        run(16'hA148, 1);
        check("busy_s_ignored", bus.datapath_in, 16'h0048);
        run(16'hD3FB, 0);
        run(16'hC0E5, 0);
        run(16'hBA9F, 0);
        run(16'hE000, 0);
        run(16'hA148, 0);
        // Reset during GET_B of ADD.
        bus.s = 1;
        bus.instr = 16'hA148;
        @(negedge clk);
        bus.s = 0;
        @(negedge clk);
        @(negedge clk);
        check("getb_loadb", bus.loadb, 1'b1);
        reset = 1;
        #1;
        check("abort_w", bus.w, 1'b1);
        check("abort_loadb", bus.loadb, 1'b0);
        check("abort_readnum", bus.readnum, 3'd0);
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            check("abort_nowrite", {bus.w, bus.write, bus.loadc}, 3'b100);
            @(negedge clk);
        end
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: r = {5'b11010, 11'($urandom)};
                1: r = {5'b11000, 11'($urandom)};
                2: r = {5'b10100, 11'($urandom)};
                3: r = {5'b10101, 11'($urandom)};
                4: r = {5'b10110, 11'($urandom)};
                5: r = {5'b10111, 11'($urandom)};
                default: begin
                    r = 16'($urandom);
                    for (int t = 0; t < 50 && legal(r); t++) r = 16'($urandom);
                    if (legal(r)) r = 16'hE000;
                end
            endcase
            run(r, 1'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
